window3_feed: RTL and testbench
===============================

Name: window3_feed

Overview:
- Upstream feeder for the 3-tap signed product-sum stage.
- Accepts a raw 10-bit signed pixel stream, one row at a time. Builds the zero-padded 3-sample sliding window (x0,x1,x2) for every column and presents it with a valid/ready handshake.
- Also holds the three 10-bit signed tap weights (w0..w2), loaded through a simple register write port, and drives them statically to the product-sum stage.

Parameters:
- W, 28, pixels per row; legal range 2..1023.
- CW, 10, column counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- clear  input  1  synchronous soft reset: aborts the current row, keeps weights
- in_valid  input  1  input pixel valid
- in_ready  output  1  block can accept a pixel this cycle
- in_data  input  10  signed pixel
- out_valid  output  1  window valid
- out_ready  input  1  downstream accepts the window
- x0  output  10  signed window sample, column c-1
- x1  output  10  signed window sample, column c
- x2  output  10  signed window sample, column c+1
- out_row_end  output  1  high with the last window of a row
- wr_en  input  1  weight write strobe
- wr_addr  input  2  weight index: 0→w0, 1→w1, 2→w2, 3 ignored
- wr_data  input  10  signed weight value
- w0  output  10  signed tap weight 0
- w1  output  10  signed tap weight 1
- w2  output  10  signed tap weight 2

Behaviour:
- Reset (resetn low, async): state=FILL; prev, cur, col = 0; out_valid=0; x0..x2=0; out_row_end=0; w0..w2=0.
- Window definition: window for column c is (p[c-1], p[c], p[c+1]), with p[-1]=p[W]=0. Each row yields exactly W windows.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Output register update: "slot free" = !out_valid | out_ready. Output registers load only when slot free. out_valid clears after an output transfer if nothing new is loaded the same cycle.
- State FILL:
  - in_ready=1.
  - On input transfer: prev<=0, cur<=in_data, col<=1, go to RUN. No window is emitted.
- State RUN:
  - in_ready = slot free.
  - On input transfer: {x0,x1,x2}<={prev,cur,in_data}; out_valid<=1; out_row_end<=0; prev<=cur; cur<=in_data; col<=col+1.
  - If col==W-1 at the transfer, go to FLUSH.
- State FLUSH:
  - in_ready=0.
  - When slot free: {x0,x1,x2}<={prev,cur,0}; out_valid<=1; out_row_end<=1; col<=0; go to FILL.
- Latency: first window appears 1 cycle after the second pixel is accepted. The row-end window appears 1 cycle after the last pixel at the earliest.
- Throughput: 1 pixel/cycle in RUN. One bubble on the input side per row for FLUSH, plus one for FILL (no output).
- Backpressure: x0..x2 and out_row_end hold stable while out_valid & !out_ready. No window is dropped or duplicated.
- Arithmetic: samples are passed through bit-exact; no arithmetic is performed. Padding zeros are 10'sd0.
- clear:
  - Takes priority over all stream activity.
  - Next state=FILL; out_valid=0; prev, cur, col = 0; out_row_end=0.
  - Any input transfer in the same cycle is discarded.
  - Weights are not affected.
- Weight write:
  - On clk when wr_en: register[wr_addr]<=wr_data. wr_addr==3 is a no-op.
  - Allowed in any state, independent of the stream; not affected by clear.
  - New value is visible on w* the cycle after the write.
- resetn asserted mid-row: all state, including weights, returns to reset values immediately. The partial row is lost.

Test Plan:
- W=4, out_ready=1, pixels 1,2,3,4 back-to-back → windows (0,1,2),(1,2,3),(2,3,4),(3,4,0); out_row_end only on the 4th; in_ready low exactly 1 cycle (FLUSH).
- W=4, two rows 1..4 then 5..8 → second row's first window (0,5,6); no sample leaks from row 1 into row 2.
- W=4, out_ready toggled 0/1 every cycle → same 4 windows in order, each held stable while stalled; in_ready=0 whenever out_valid & !out_ready in RUN.
- Boundary values, pixels -512,511,-1,0 → windows (0,-512,511),(-512,511,-1),(511,-1,0),(-1,0,0); sign bits preserved.
- Weights: write w0=-3, w1=7, w2=511, then addr 3 = 100 → w0..w2 read -3,7,511, unchanged by the addr-3 write; clear pulse leaves them intact.
- After 2 pixels of a W=4 row: assert clear → out_valid=0 next cycle, next pixel 9 treated as column 0, windows restart with (0,9,·). Repeat with resetn pulse → weights also return to 0.

Source files
------------

// File: rtl/window3_feed.sv
// Sliding 3-sample window feeder with zero padding at row edges, plus the
// register file holding the three tap weights for the product-sum stage.
module window3_feed #(
    parameter int W  = 28,
    parameter int CW = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  x0,
    output logic [9:0]  x1,
    output logic [9:0]  x2,
    output logic        out_row_end,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [9:0]  wr_data,
    output logic [9:0]  w0,
    output logic [9:0]  w1,
    output logic [9:0]  w2
);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

    state_t          state, state_next;
    logic [9:0]      prev, cur;
    logic [CW-1:0]   col;
    logic            slot_free;
    logic            fill_take, run_take, flush_load;

    assign slot_free = !out_valid || out_ready;

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        fill_take  = 1'b0;
        run_take   = 1'b0;
        flush_load = 1'b0;
        case (state)
            FILL: begin
                in_ready  = 1'b1;
                fill_take = in_valid;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                in_ready = slot_free;
                run_take = in_valid && slot_free;
                if (run_take && col == LAST_COL) state_next = FLUSH;
            end
            FLUSH: begin
                flush_load = slot_free;
                if (slot_free) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
        if (clear) state_next = FILL;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= FILL;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev        <= '0;
            cur         <= '0;
            col         <= '0;
            out_valid   <= 1'b0;
            out_row_end <= 1'b0;
            x0          <= '0;
            x1          <= '0;
            x2          <= '0;
        end else if (clear) begin
            // Window samples are left as-is; out_valid low makes them don't-care.
            prev        <= '0;
            cur         <= '0;
            col         <= '0;
            out_valid   <= 1'b0;
            out_row_end <= 1'b0;
        end else begin
            if (run_take || flush_load) begin
                x0          <= prev;
                x1          <= cur;
                x2          <= run_take ? in_data : 10'd0;
                out_valid   <= 1'b1;
                out_row_end <= flush_load;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (fill_take) begin
                prev <= '0;
                cur  <= in_data;
                col  <= CW'(1);
            end else if (run_take) begin
                prev <= cur;
                cur  <= in_data;
                col  <= col + 1'b1;
            end else if (flush_load) begin
                col <= '0;
            end
        end
    end

    // Weights ignore clear; only the hard reset returns them to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w0 <= '0;
            w1 <= '0;
            w2 <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    w0 <= wr_data;
                2'd1:    w1 <= wr_data;
                2'd2:    w2 <= wr_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window3_feed.sv
// Self-checking bench for window3_feed: randomized rows checked against a
// queue-based model of the zero-padded sliding window.
module tb_window3_feed;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] x0, x1, x2;
    logic       out_row_end;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [9:0] wr_data;
    logic [9:0] w0, w1, w2;

    window3_feed #(.W(W), .CW(10)) dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(x0), .x1(x1), .x2(x2), .out_row_end(out_row_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .w0(w0), .w1(w1), .w2(w2)
    );

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] c;
        logic       e;
    } win_t;

    win_t exp_q[$];
    win_t obs_q[$];
    int   errors = 0;
    int   checks = 0;
    int   stall_cycles = 0;
    int   stable_viol = 0;
    int   iready_viol = 0;
    int   ready_mode = 0;   // 0 hold, 1 toggle, 2 random
    logic held_v = 1'b0;
    win_t held;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)      out_ready = ~out_ready;
        else if (ready_mode == 2) out_ready = 1'($urandom % 2);
    end

    // Passive monitor: records accepted windows, tracks hold and ready rules.
    always @(negedge clk) begin
        if (resetn && !clear) begin
            if (out_valid && out_ready)
                obs_q.push_back('{x0, x1, x2, out_row_end});
            if (held_v && out_valid && held != win_t'({x0, x1, x2, out_row_end}))
                stable_viol++;
            if (out_valid && !out_ready && !out_row_end && in_ready)
                iready_viol++;
        end
        held_v = resetn && !clear && out_valid && !out_ready;
        held   = '{x0, x1, x2, out_row_end};
    end

    function automatic void model_row(input logic [9:0] p[$]);
        for (int c = 0; c < W; c++) begin
            win_t w;
            w.a = (c > 0)     ? p[c-1] : 10'd0;
            w.b = p[c];
            w.c = (c < W - 1) ? p[c+1] : 10'd0;
            w.e = (c == W - 1);
            exp_q.push_back(w);
        end
    endfunction

    task automatic push_pixel(input logic [9:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            stall_cycles++;
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [9:0] p[$]);
        model_row(p);
        foreach (p[i]) push_pixel(p[i]);
    endtask

    task automatic compare_stream(input string name);
        int n = 0;
        int m;
        while (obs_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d windows, required %0d", name, obs_q.size(), exp_q.size());
        end
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_win%0d: got (%0d,%0d,%0d,end=%0b) required (%0d,%0d,%0d,end=%0b)",
                         name, i, $signed(obs_q[i].a), $signed(obs_q[i].b), $signed(obs_q[i].c), obs_q[i].e,
                         $signed(exp_q[i].a), $signed(exp_q[i].b), $signed(exp_q[i].c), exp_q[i].e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [1:0] a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_weights(input string name, input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
        checks++;
        if ({w0, w1, w2} !== {e0, e1, e2}) begin
            errors++;
            $display("FAIL %s: got w=(%0d,%0d,%0d) required (%0d,%0d,%0d)", name,
                     $signed(w0), $signed(w1), $signed(w2), $signed(e0), $signed(e1), $signed(e2));
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_row_end, x0, x1, x2} !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b end=%0b x=(%0d,%0d,%0d) required all 0",
                     out_valid, out_row_end, x0, x1, x2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        check_weights("reset_weights", 10'd0, 10'd0, 10'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_row();
        logic [9:0] r[$] = '{10'd1, 10'd2, 10'd3, 10'd4};
        push_row(r);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %0b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_in_ready: got %0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        compare_stream("single_row");
    endtask

    task automatic test_back_to_back();
        logic [9:0] r1[$] = '{10'd1, 10'd2, 10'd3, 10'd4};
        logic [9:0] r2[$] = '{10'd5, 10'd6, 10'd7, 10'd8};
        stall_cycles = 0;
        push_row(r1);
        push_row(r2);
        in_valid = 1'b0;
        checks++;
        if (stall_cycles !== 1) begin
            errors++;
            $display("FAIL b2b_bubbles: got %0d stall cycles, required 1", stall_cycles);
        end
        compare_stream("back_to_back");
    endtask

    task automatic test_backpressure();
        logic [9:0] r[$] = '{10'd21, 10'd22, 10'd23, 10'd24};
        stable_viol = 0;
        iready_viol = 0;
        ready_mode  = 1;
        push_row(r);
        in_valid = 1'b0;
        compare_stream("backpressure");
        ready_mode = 0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stable_viol !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stalled cycles, required 0", stable_viol);
        end
        checks++;
        if (iready_viol !== 0) begin
            errors++;
            $display("FAIL bp_in_ready: got %0d cycles with in_ready high while stalled, required 0", iready_viol);
        end
    endtask

    task automatic test_boundary();
        logic [9:0] r[$] = '{10'h200, 10'h1FF, 10'h3FF, 10'h000};
        push_row(r);
        in_valid = 1'b0;
        compare_stream("boundary");
    endtask

    task automatic test_weights();
        write_w(2'd0, 10'h3FD);
        write_w(2'd1, 10'd7);
        write_w(2'd2, 10'd511);
        @(negedge clk);
        check_weights("weights_written", 10'h3FD, 10'd7, 10'd511);
        @(posedge clk);
        #1;
        write_w(2'd3, 10'd100);
        @(negedge clk);
        check_weights("weights_addr3", 10'h3FD, 10'd7, 10'd511);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check_weights("weights_after_clear", 10'h3FD, 10'd7, 10'd511);
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        logic [9:0] r[$] = '{10'd9, 10'd10, 10'd11, 10'd12};
        push_pixel(10'd30);
        push_pixel(10'd31);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'd77;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_out_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_in_ready: got %0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_data = 10'd78;   // offered while clear is still high: must be dropped
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        obs_q.delete();
        push_row(r);
        in_valid = 1'b0;
        compare_stream("after_clear");
    endtask

    task automatic test_resetn_midrow();
        logic [9:0] r[$] = '{10'd13, 10'd14, 10'd15, 10'd16};
        write_w(2'd0, 10'd5);
        write_w(2'd2, 10'h3F0);
        push_pixel(10'd40);
        push_pixel(10'd41);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL resetn_out_valid: got %0b required 0", out_valid);
        end
        check_weights("resetn_weights", 10'd0, 10'd0, 10'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        push_row(r);
        in_valid = 1'b0;
        compare_stream("after_resetn");
    endtask

    task automatic test_random();
        stable_viol = 0;
        ready_mode  = 2;
        for (int row = 0; row < 6; row++) begin
            logic [9:0] r[$];
            for (int c = 0; c < W; c++) r.push_back(10'($urandom));
            push_row(r);
            if ($urandom % 2 == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        compare_stream("random");
        checks++;
        if (stable_viol !== 0) begin
            errors++;
            $display("FAIL random_hold: got %0d unstable stalled cycles, required 0", stable_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_weights();
        test_clear();
        test_resetn_midrow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
